// File: rtl/gshare_predictor.sv
// gshare branch predictor: PC xor global history indexes a table of
// saturating counters; trained non-speculatively by resolved branches.
module gshare_predictor #(
    parameter int PC_BITS    = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 6,
    parameter int CTR_INIT   = 2**(CTR_BITS-1)-1,
    parameter int STAT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  request,
    input  logic [PC_BITS-1:0]    req_pc,
    output logic                  pred_valid,
    output logic                  prediction,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  result,
    input  logic [INDEX_BITS-1:0] res_index,
    input  logic                  taken,
    input  logic                  res_pred,
    output logic [STAT_BITS-1:0]  mispredicts
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
    localparam logic [STAT_BITS-1:0] STAT_MAX = '1;
    localparam logic [CTR_BITS-1:0]  CTR_RST  = CTR_BITS'(CTR_INIT);

    logic [CTR_BITS-1:0]   tbl [DEPTH];
    logic [HIST_BITS-1:0]  ghr;
    logic [HIST_BITS-1:0]  ghr_nxt;
    logic [INDEX_BITS-1:0] idx;
    logic [CTR_BITS-1:0]   cur;
    logic [CTR_BITS-1:0]   ctr_nxt;
    logic                  unused_pc;

    assign idx = req_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
    assign cur = tbl[res_index];
    assign unused_pc = ^{req_pc >> (INDEX_BITS+2), req_pc[1:0]};

    always_comb begin
        ctr_nxt = cur;
        if (taken && cur != CTR_MAX)
            ctr_nxt = cur + 1'b1;
        else if (!taken && cur != '0)
            ctr_nxt = cur - 1'b1;
    end

    generate
        if (HIST_BITS == 1) begin : g_h1
            assign ghr_nxt = taken;
        end else begin : g_hn
            assign ghr_nxt = {ghr[HIST_BITS-2:0], taken};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                tbl[i] <= CTR_RST;
        end else if (result) begin
            tbl[res_index] <= ctr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr         <= '0;
            mispredicts <= '0;
        end else if (result) begin
            ghr <= ghr_nxt;
            if (taken != res_pred && mispredicts != STAT_MAX)
                mispredicts <= mispredicts + 1'b1;
        end
    end

    // Read uses pre-edge table/ghr, so same-cycle updates are not bypassed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            prediction <= 1'b0;
            pred_index <= '0;
        end else begin
            pred_valid <= request;
            if (request) begin
                pred_index <= idx;
                prediction <= tbl[idx][CTR_BITS-1];
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed vector table, small-parameter
// instance, and randomized traffic against an integer reference model.
module tb_gshare_predictor;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        req = 0;
    logic [31:0] pc = 0;
    logic        res = 0;
    logic [5:0]  ridx = 0;
    logic        tkn = 0;
    logic        rp = 0;
    logic        a_pv, a_p, b_pv, b_p;
    logic [5:0]  a_pi, b_pi;
    logic [15:0] a_m;
    logic [1:0]  b_m;

    logic        c_req = 0;
    logic [31:0] c_pc = 0;
    logic        c_res = 0;
    logic [3:0]  c_ridx = 0;
    logic        c_tkn = 0;
    logic        c_rp = 0;
    logic        c_pv, c_p;
    logic [3:0]  c_pi;
    logic [15:0] c_m;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    gshare_predictor u_a (
        .clk(clk), .rst_n(rst_n), .request(req), .req_pc(pc),
        .pred_valid(a_pv), .prediction(a_p), .pred_index(a_pi),
        .result(res), .res_index(ridx), .taken(tkn), .res_pred(rp),
        .mispredicts(a_m)
    );

    gshare_predictor #(.STAT_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .request(req), .req_pc(pc),
        .pred_valid(b_pv), .prediction(b_p), .pred_index(b_pi),
        .result(res), .res_index(ridx), .taken(tkn), .res_pred(rp),
        .mispredicts(b_m)
    );

    gshare_predictor #(.INDEX_BITS(4), .HIST_BITS(2), .CTR_BITS(3)) u_c (
        .clk(clk), .rst_n(rst_n), .request(c_req), .req_pc(c_pc),
        .pred_valid(c_pv), .prediction(c_p), .pred_index(c_pi),
        .result(c_res), .res_index(c_ridx), .taken(c_tkn), .res_pred(c_rp),
        .mispredicts(c_m)
    );

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        res;
        logic [5:0]  ri;
        logic        t;
        logic        rp;
        logic        ev;
        logic        ep;
        logic [5:0]  ei;
        int          em;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic a_step(input logic q, input logic [31:0] p,
                          input logic r, input logic [5:0] i,
                          input logic t, input logic d);
        req = q; pc = p; res = r; ridx = i; tkn = t; rp = d;
        @(posedge clk); #1;
    endtask

    task automatic c_step(input logic q, input logic [31:0] p,
                          input logic r, input logic [3:0] i,
                          input logic t, input logic d);
        c_req = q; c_pc = p; c_res = r; c_ridx = i; c_tkn = t; c_rp = d;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        a_step(0, 0, 0, 0, 0, 0);
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    // reference model state
    int tm[64];
    int ghr_m, misp_m, mi, mi_n;
    bit mv, mp;

    initial begin
        vt[0]  = '{1, 32'h40, 0,  0, 0, 0, 1, 0, 16, 0};
        vt[1]  = '{0, 32'h0,  1, 16, 1, 0, 0, 0, 16, 1};
        vt[2]  = '{0, 32'h0,  1, 16, 1, 0, 0, 0, 16, 2};
        vt[3]  = '{0, 32'h0,  1, 16, 1, 0, 0, 0, 16, 3};
        vt[4]  = '{1, 32'h5C, 0,  0, 0, 0, 1, 1, 16, 3};
        vt[5]  = '{0, 32'h0,  1, 16, 1, 1, 0, 1, 16, 3};
        vt[6]  = '{1, 32'h7C, 0,  0, 0, 0, 1, 1, 16, 3};
        vt[7]  = '{0, 32'h0,  1,  5, 0, 0, 0, 1, 16, 3};
        vt[8]  = '{0, 32'h0,  1,  5, 0, 0, 0, 1, 16, 3};
        vt[9]  = '{1, 32'hE4, 0,  0, 0, 0, 1, 0,  5, 3};
        vt[10] = '{1, 32'hD4, 1,  9, 1, 0, 1, 0,  9, 4};
        vt[11] = '{1, 32'hC0, 0,  0, 0, 0, 1, 1,  9, 4};

        #2;
        chk("async_rst_valid", {31'b0, a_pv}, 0);
        chk("async_rst_misp", {16'b0, a_m}, 0);
        do_reset();
        chk("rst_valid", {31'b0, a_pv}, 0);
        chk("rst_pred", {31'b0, a_p}, 0);
        chk("rst_index", {26'b0, a_pi}, 0);
        chk("rst_misp", {16'b0, a_m}, 0);

        // small-parameter instance: xor index and 3-bit saturation
        c_step(1, 32'h28, 0, 0, 0, 0);
        chk("c_idx0", {28'b0, c_pi}, 10);
        chk("c_pred0", {31'b0, c_p}, 0);
        repeat (5) c_step(0, 0, 1, 10, 1, 0);
        c_step(1, 32'hFFFF_FFE7, 0, 0, 0, 0);
        chk("c_idx_xor", {28'b0, c_pi}, 10);
        chk("c_pred_hi", {31'b0, c_p}, 1);
        repeat (3) c_step(0, 0, 1, 10, 0, 0);
        c_step(1, 32'h28, 0, 0, 0, 0);
        chk("c_sat7_pred", {31'b0, c_p}, 1);
        c_step(0, 0, 1, 10, 0, 0);
        c_step(1, 32'h28, 0, 0, 0, 0);
        chk("c_dec_pred", {31'b0, c_p}, 0);
        chk("c_misp", {16'b0, c_m}, 5);
        c_step(0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            a_step(vt[k].req, vt[k].pc, vt[k].res, vt[k].ri,
                   vt[k].t, vt[k].rp);
            chk($sformatf("vec%0d_valid", k), {31'b0, a_pv}, {31'b0, vt[k].ev});
            chk($sformatf("vec%0d_pred", k), {31'b0, a_p}, {31'b0, vt[k].ep});
            chk($sformatf("vec%0d_idx", k), {26'b0, a_pi}, {26'b0, vt[k].ei});
            chk($sformatf("vec%0d_misp", k), {16'b0, a_m}, vt[k].em);
            chk($sformatf("vec%0d_bmisp", k), {30'b0, b_m},
                vt[k].em > 3 ? 3 : vt[k].em);
        end

        // randomized traffic against the integer model
        do_reset();
        foreach (tm[i]) tm[i] = 1;
        ghr_m = 0; misp_m = 0; mi = 0; mp = 0; mv = 0;
        for (int n = 0; n < 2000; n++) begin
            logic q, r, t, d;
            logic [31:0] p;
            logic [5:0] ri;
            q = 1'($urandom); r = 1'($urandom_range(0, 3) != 0);
            t = 1'($urandom); d = 1'($urandom);
            p = $urandom; ri = 6'($urandom_range(0, 63));
            mv = q;
            if (q) begin
                mi_n = int'((p >> 2) & 32'h3f) ^ ghr_m;
                mi = mi_n;
                mp = tm[mi] >= 2;
            end
            if (r) begin
                if (t) tm[ri] = (tm[ri] + 1 > 3) ? 3 : tm[ri] + 1;
                else   tm[ri] = (tm[ri] - 1 < 0) ? 0 : tm[ri] - 1;
                ghr_m = (ghr_m * 2 + int'(t)) % 64;
                if (t != d && misp_m < 65535) misp_m++;
            end
            a_step(q, p, r, ri, t, d);
            if (a_pv !== mv || a_p !== mp || a_pi !== 6'(mi)) begin
                ntotal++;
                $display("FAIL rand%0d_pred: got v%0b p%0b i%0d expected v%0b p%0b i%0d",
                         n, a_pv, a_p, a_pi, mv, mp, mi);
            end else begin
                ntotal++; npass++;
            end
            chk($sformatf("rand%0d_misp", n), {16'b0, a_m}, misp_m);
            chk($sformatf("rand%0d_bmisp", n), {30'b0, b_m},
                misp_m > 3 ? 3 : misp_m);
        end

        // mid-stream asynchronous reset, no clock edge
        a_step(1, 32'hFC, 1, 7, 1, 0);
        rst_n = 0;
        req = 0; res = 0;
        #1;
        chk("mid_rst_valid", {31'b0, a_pv}, 0);
        chk("mid_rst_pred", {31'b0, a_p}, 0);
        chk("mid_rst_idx", {26'b0, a_pi}, 0);
        chk("mid_rst_misp", {16'b0, a_m}, 0);
        chk("mid_rst_bmisp", {30'b0, b_m}, 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            a_step(1, 32'(i) << 2, 0, 0, 0, 0);
            chk($sformatf("init%0d_idx", i), {26'b0, a_pi}, i);
            chk($sformatf("init%0d_pred", i), {31'b0, a_p}, 0);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
